e_rr_arb: RTL and testbench

Round-robin arbiter that grants one of `W` requestors at a time and holds the grant for a multi-beat transaction until its last beat is accepted. It sits directly upstream of the one-hot admission check `e_is_1hot`. `o_gnt` is the vector that block qualifies, so `o_gnt` must be one-hot whenever `o_gnt_vld` is high and all-zero otherwise. Arbitration is fair: after a transaction completes, priority rotates to the requestor following the one just served.

---
 rtl/e_pkg.sv | 9 +
 rtl/e_is_1hot.sv | 11 +
 rtl/e_rr_pick.sv | 38 +++
 rtl/e_rr_arb.sv | 96 +++++++++
 tb/tb_e_rr_arb.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/e_pkg.sv
// Shared types for the round-robin arbiter and its helpers.
package e_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } e_rr_arb_state_t;

endpackage

// File: rtl/e_is_1hot.sv
// One-hot admission check: high only when exactly one bit of i_vec is set.
module e_is_1hot #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_vec,
  output logic         o_1hot
);

  assign o_1hot = (i_vec != '0) && ((i_vec & (i_vec - W'(1))) == '0);

endmodule

// File: rtl/e_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr,
// wrapping modulo W.
module e_rr_pick #(
  parameter  int W     = 4,
  localparam int W_IDX = $clog2(W)
) (
  input  logic [W-1:0]     i_req,
  input  logic [W_IDX-1:0] i_ptr,
  output logic [W-1:0]     o_1hot,
  output logic [W_IDX-1:0] o_idx,
  output logic             o_any
);

  localparam logic [W_IDX:0] W_EXT = (W_IDX+1)'(W);

  logic [2*W-1:0]   w_dbl;
  logic [W-1:0]     w_rot;
  logic [W_IDX-1:0] w_off;
  logic [W_IDX:0]   w_sum;

  // Rotating through a doubled copy puts requestor i_ptr at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = W'(w_dbl >> i_ptr);

  always_comb begin
    w_off = '0;
    for (int k = W - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = W_IDX'(k);
    end
    w_sum = {1'b0, i_ptr} + {1'b0, w_off};
    if (w_sum >= W_EXT) w_sum = w_sum - W_EXT;
  end

  assign o_any  = |w_rot;
  assign o_idx  = o_any ? w_sum[W_IDX-1:0] : '0;
  assign o_1hot = o_any ? (W'(1) << o_idx) : '0;

endmodule

// File: rtl/e_rr_arb.sv
// Round-robin arbiter holding each grant until the granted requestor's last
// beat is accepted; priority rotates past the requestor just served.
module e_rr_arb
  import e_pkg::*;
#(
  parameter  int W     = 4,
  localparam int W_IDX = $clog2(W)
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic [W-1:0]     i_req,
  input  logic [W-1:0]     i_last,
  input  logic             i_ack,
  output logic [W-1:0]     o_gnt,
  output logic             o_gnt_vld,
  output logic [W_IDX-1:0] o_gnt_idx
);

  e_rr_arb_state_t  r_state;
  logic [W_IDX-1:0] r_ptr;
  logic [W-1:0]     r_gnt;
  logic             r_gnt_vld;
  logic [W_IDX-1:0] r_gnt_idx;

  logic             w_busy;
  logic             w_rel;
  logic [W_IDX-1:0] w_next_ptr;
  logic [W-1:0]     w_pick_req;
  logic [W_IDX-1:0] w_pick_ptr;
  logic [W-1:0]     w_pick_1hot;
  logic [W_IDX-1:0] w_pick_idx;
  logic             w_pick_any;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_rel      = w_busy && i_ack && i_last[r_gnt_idx];
  assign w_next_ptr = (r_gnt_idx == W_IDX'(W - 1)) ? '0 : r_gnt_idx + W_IDX'(1);

  // While busy the picker only matters on release, so it always sees the
  // post-release view: granted bit masked, pointer already advanced.
  assign w_pick_req = w_busy ? (i_req & ~r_gnt) : i_req;
  assign w_pick_ptr = w_busy ? w_next_ptr : r_ptr;

  e_rr_pick #(.W(W)) u_pick (
    .i_req  (w_pick_req),
    .i_ptr  (w_pick_ptr),
    .o_1hot (w_pick_1hot),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state   <= ST_BUSY;
            r_gnt     <= w_pick_1hot;
            r_gnt_vld <= 1'b1;
            r_gnt_idx <= w_pick_idx;
          end
        end
        ST_BUSY: begin
          if (w_rel) begin
            r_ptr <= w_next_ptr;
            if (w_pick_any) begin
              r_gnt     <= w_pick_1hot;
              r_gnt_idx <= w_pick_idx;
            end else begin
              r_state   <= ST_IDLE;
              r_gnt     <= '0;
              r_gnt_vld <= 1'b0;
              r_gnt_idx <= '0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gnt     <= '0;
          r_gnt_vld <= 1'b0;
          r_gnt_idx <= '0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_vld = r_gnt_vld;
  assign o_gnt_idx = r_gnt_idx;

endmodule

// File: tb/tb_e_rr_arb.sv
// Bench for e_rr_arb: directed scenarios plus random traffic against a
// behavioural round-robin model, checked through an expected-value queue.
module tb_e_rr_arb;

  localparam int W     = 4;
  localparam int W_IDX = 2;
  localparam int EW    = W + 1 + W_IDX;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [W-1:0]     req;
  logic [W-1:0]     last;
  logic             ack;
  logic [W-1:0]     gnt;
  logic             vld;
  logic [W_IDX-1:0] idx;
  logic             w_is_1hot;

  logic [EW-1:0] exp_q[$];
  int  checks  = 0;
  int  errors  = 0;
  bit  started = 1'b0;

  // reference model state
  bit m_busy;
  int m_ptr;
  int m_idx;

  always #5 clk = ~clk;

  e_rr_arb #(.W(W)) dut (
    .i_clk     (clk),
    .i_arst_n  (rst_n),
    .i_req     (req),
    .i_last    (last),
    .i_ack     (ack),
    .o_gnt     (gnt),
    .o_gnt_vld (vld),
    .o_gnt_idx (idx)
  );

  e_is_1hot #(.W(W)) u_chk (
    .i_vec  (gnt),
    .o_1hot (w_is_1hot)
  );

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [W-1:0] r, input int p);
    for (int k = 0; k < W; k++) begin
      int j;
      j = (p + k) % W;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_busy = 1'b0;
    m_ptr  = 0;
    m_idx  = 0;
  endfunction

  function automatic void m_step(input logic [W-1:0] r, input logic [W-1:0] l, input bit a);
    int p;
    logic [W-1:0] masked;
    if (!m_busy) begin
      p = pick(r, m_ptr);
      if (p >= 0) begin
        m_busy = 1'b1;
        m_idx  = p;
      end
    end else if (a && l[m_idx]) begin
      m_ptr  = (m_idx + 1) % W;
      masked = r;
      masked[m_idx] = 1'b0;
      p = pick(masked, m_ptr);
      if (p >= 0) m_idx = p;
      else begin
        m_busy = 1'b0;
        m_idx  = 0;
      end
    end
  endfunction

  function automatic logic [EW-1:0] m_out();
    logic [W-1:0]     g;
    logic [W_IDX-1:0] ix;
    g  = '0;
    ix = '0;
    if (m_busy) begin
      g[m_idx] = 1'b1;
      ix = W_IDX'(m_idx);
    end
    return {m_busy, g, ix};
  endfunction

  // One clock of stimulus; rst=0 holds reset for this cycle.
  task automatic step(input bit rst, input logic [W-1:0] r, input logic [W-1:0] l, input bit a);
    bit was_run;
    @(negedge clk);
    req  = r;
    last = l;
    ack  = a;
    if (!rst) begin
      was_run = rst_n;
      rst_n   = 1'b0;
      m_reset();
      exp_q.push_back('0);
      if (was_run) begin
        #1;
        check("async_reset", {vld, gnt, idx}, '0);
      end
    end else begin
      rst_n = 1'b1;
      m_step(r, l, a);
      exp_q.push_back(m_out());
    end
  endtask

  initial begin
    logic [EW-1:0] e;
    wait (started);
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant", {vld, gnt, idx}, e);
      end
      check("is_1hot_vs_vld", EW'(w_is_1hot), EW'(vld));
    end
  end

  initial begin
    int n;
    rst_n = 1'b1;
    req   = '0;
    last  = '0;
    ack   = 1'b0;
    m_reset();
    #2 rst_n = 1'b0;
    #1 started = 1'b1;

    // reset held with all requests, then first grant after release of reset
    repeat (3) step(0, 4'b1111, 4'b0000, 0);
    step(1, 4'b1111, 4'b0000, 0);
    step(1, 4'b1111, 4'b0000, 0);

    // single requestor, then ptr=2 shows up as req2 winning full contention
    step(0, 4'b0000, 4'b0000, 0);
    step(1, 4'b0010, 4'b0010, 1);
    step(1, 4'b0010, 4'b0010, 1);
    step(1, 4'b0000, 4'b0000, 0);
    step(1, 4'b1111, 4'b0000, 0);

    // full contention, single-beat
    step(0, 4'b0000, 4'b0000, 0);
    repeat (6) step(1, 4'b1111, 4'b1111, 1);

    // multi-beat with stall, then wrap after req3
    step(0, 4'b0000, 4'b0000, 0);
    step(1, 4'b0101, 4'b0000, 0);
    step(1, 4'b0101, 4'b0000, 1);
    step(1, 4'b0101, 4'b0000, 0);
    step(1, 4'b0101, 4'b0000, 1);
    step(1, 4'b0101, 4'b0001, 1);
    step(1, 4'b0100, 4'b0100, 1);
    step(1, 4'b1000, 4'b1000, 1);
    step(1, 4'b1000, 4'b1000, 1);
    step(1, 4'b1001, 4'b1001, 1);
    step(1, 4'b1001, 4'b1001, 1);
    step(1, 4'b1000, 4'b1000, 1);
    step(1, 4'b0000, 4'b0000, 0);

    // reset in the middle of a multi-beat grant to req1
    step(1, 4'b0010, 4'b0000, 0);
    step(1, 4'b0010, 4'b0000, 1);
    step(0, 4'b0010, 4'b0000, 1);
    step(0, 4'b0010, 4'b0000, 0);
    step(1, 4'b0010, 4'b0000, 0);
    step(1, 4'b0010, 4'b0010, 1);
    step(1, 4'b1111, 4'b0000, 0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) != 0),
           W'($urandom_range(0, 15)),
           W'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
